// File: rtl/muldiv_unit_if.sv
// -----------------------------------------------------------------------------
// muldiv_unit_if
//   Bundles the EX-stage operand/request lines and the HI/LO/Busy results of
//   the multiply/divide unit.
//   master : issues requests (A, B, Start, MdOp), observes Busy/HI/LO
//   slave  : the muldiv_unit itself
//   Signals:
//     A     [31:0] operand rs (dividend / multiplicand / MTHI-MTLO source)
//     B     [31:0] operand rt (divisor / multiplier)
//     Start        one-cycle request, MdOp valid with it
//     MdOp  [2:0]  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MSUB
//     Busy         high while a multi-cycle op is in flight
//     HI    [31:0] architectural HI register
//     LO    [31:0] architectural LO register
// -----------------------------------------------------------------------------
interface muldiv_unit_if;
  logic [31:0] A;
  logic [31:0] B;
  logic        Start;
  logic [2:0]  MdOp;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output A, B, Start, MdOp, input Busy, HI, LO);
  modport slave  (input A, B, Start, MdOp, output Busy, HI, LO);
endinterface

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   EX-stage multiply/divide unit sitting beside the ALU. MULT/MULTU/DIV/DIVU
//   compute their 64-bit result when the request is accepted, hold it in
//   pending registers, and commit it to HI/LO after a fixed busy period.
//   MTHI/MTLO write HI/LO directly in one cycle.
//
//   Optional feature: define MULDIV_MADD_EN to enable MADD (op 6) and MSUB
//   (op 7), which accumulate a signed product into {HI,LO} at commit time.
//   Without the macro ops 6/7 are no-ops.
//
//   Parameters:
//     MULT_CYCLES  busy cycles for MULT/MULTU/MADD/MSUB (1..15)
//     DIV_CYCLES   busy cycles for DIV/DIVU (1..15)
//   Ports:
//     clk    clock, all state updates on the rising edge
//     reset  synchronous active-high reset, clears all state, wins over Start
//     md     muldiv_unit_if.slave (A, B, Start, MdOp in; Busy, HI, LO out)
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic          clk,
  input  logic          reset,
  muldiv_unit_if.slave  md
);

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MADD  = 3'd6,
    OP_MSUB  = 3'd7
  } op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // Arithmetic helpers
  // ---------------------------------------------------------------------------
  function automatic logic signed [63:0] mul_s(input logic signed [31:0] a,
                                               input logic signed [31:0] b);
    logic signed [63:0] ax;
    logic signed [63:0] bx;
    ax = a;
    bx = b;
    return ax * bx;
  endfunction

  function automatic logic [63:0] mul_u(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ax;
    logic [63:0] bx;
    ax = {32'd0, a};
    bx = {32'd0, b};
    return ax * bx;
  endfunction

  // Returns {remainder, quotient}. The most-negative / -1 case is pinned
  // explicitly so the quotient wraps to 0x80000000 with a zero remainder.
  function automatic logic [63:0] div_s(input logic signed [31:0] n,
                                        input logic signed [31:0] d);
    logic signed [31:0] q;
    logic signed [31:0] r;
    if (d == 32'sd0) begin
      q = '0;
      r = '0;
    end else if (n == 32'sh8000_0000 && d == -32'sd1) begin
      q = n;
      r = '0;
    end else begin
      q = n / d;
      r = n % d;
    end
    return {r, q};
  endfunction

  function automatic logic [63:0] div_u(input logic [31:0] n, input logic [31:0] d);
    logic [31:0] q;
    logic [31:0] r;
    if (d == 32'd0) begin
      q = '0;
      r = '0;
    end else begin
      q = n / d;
      r = n % d;
    end
    return {r, q};
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e      state;
  state_e      state_n;
  logic [3:0]  cnt;
  logic [3:0]  cnt_n;

  logic [31:0] hi_r;
  logic [31:0] lo_r;

  logic [63:0] pend_p1;       // result captured at acceptance
  logic        pend_wr_p1;    // 0 for divide-by-zero: commit leaves HI/LO alone
  logic        pend_acc_p1;   // accumulate into {HI,LO} instead of overwrite
  logic        pend_sub_p1;   // accumulate by subtraction

  logic        accept;
  logic        commit;
  logic        wr_hi;
  logic        wr_lo;

  logic [63:0] res_d;
  logic        wr_d;
  logic        acc_d;
  logic        sub_d;

  op_e         op;
  assign op = op_e'(md.MdOp);

  // ---------------------------------------------------------------------------
  // Next-state / control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    commit  = 1'b0;
    wr_hi   = 1'b0;
    wr_lo   = 1'b0;
    case (state)
      S_IDLE: begin
        if (md.Start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              accept  = 1'b1;
              cnt_n   = 4'(MULT_CYCLES);
              state_n = S_BUSY;
            end
            OP_DIV, OP_DIVU: begin
              accept  = 1'b1;
              cnt_n   = 4'(DIV_CYCLES);
              state_n = S_BUSY;
            end
            OP_MTHI: wr_hi = 1'b1;
            OP_MTLO: wr_lo = 1'b1;
`ifdef MULDIV_MADD_EN
            OP_MADD, OP_MSUB: begin
              accept  = 1'b1;
              cnt_n   = 4'(MULT_CYCLES);
              state_n = S_BUSY;
            end
`else
            OP_MADD, OP_MSUB: ;
`endif
            default: ;
          endcase
        end
      end
      S_BUSY: begin
        // The counter holds the number of busy cycles left including this one.
        if (cnt == 4'd1) begin
          commit  = 1'b1;
          cnt_n   = 4'd0;
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Result selection at acceptance
  // ---------------------------------------------------------------------------
  always_comb begin
    res_d = '0;
    wr_d  = 1'b1;
    acc_d = 1'b0;
    sub_d = 1'b0;
    case (op)
      OP_MULT:  res_d = mul_s(md.A, md.B);
      OP_MULTU: res_d = mul_u(md.A, md.B);
      OP_DIV: begin
        res_d = div_s(md.A, md.B);
        wr_d  = (md.B != 32'd0);
      end
      OP_DIVU: begin
        res_d = div_u(md.A, md.B);
        wr_d  = (md.B != 32'd0);
      end
      OP_MADD: begin
        res_d = mul_s(md.A, md.B);
        acc_d = 1'b1;
      end
      OP_MSUB: begin
        res_d = mul_s(md.A, md.B);
        acc_d = 1'b1;
        sub_d = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stage p1: pending result, committed to HI/LO at counter expiry
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_r        <= '0;
      lo_r        <= '0;
      pend_p1     <= '0;
      pend_wr_p1  <= 1'b0;
      pend_acc_p1 <= 1'b0;
      pend_sub_p1 <= 1'b0;
    end else begin
      if (accept) begin
        pend_p1     <= res_d;
        pend_wr_p1  <= wr_d;
        pend_acc_p1 <= acc_d;
        pend_sub_p1 <= sub_d;
      end
      if (wr_hi) hi_r <= md.A;
      if (wr_lo) lo_r <= md.A;
      if (commit && pend_wr_p1) begin
        if (pend_acc_p1) begin
          if (pend_sub_p1) {hi_r, lo_r} <= {hi_r, lo_r} - pend_p1;
          else             {hi_r, lo_r} <= {hi_r, lo_r} + pend_p1;
        end else begin
          {hi_r, lo_r} <= pend_p1;
        end
      end
    end
  end

  assign md.Busy = (state == S_BUSY);
  assign md.HI   = hi_r;
  assign md.LO   = lo_r;

endmodule
